// File: rtl/disp_src_sched_if.sv
// rtl/disp_src_sched_if.sv - source inputs and display outputs of the display source scheduler
interface disp_src_sched_if;
    logic        src0_req, src1_req, src2_req;
    logic        src0_vld, src1_vld, src2_vld;
    logic [19:0] src0_data, src1_data, src2_data;
    logic [2:0]  src0_dp, src1_dp, src2_dp;
    logic [23:0] bcd;
    logic [5:0]  dp_sel;
    logic        upd;
    logic        busy;
    logic [1:0]  cur_src;

    modport slave (
        input  src0_req, src1_req, src2_req, src0_vld, src1_vld, src2_vld,
        input  src0_data, src1_data, src2_data, src0_dp, src1_dp, src2_dp,
        output bcd, dp_sel, upd, busy, cur_src
    );
    modport master (
        output src0_req, src1_req, src2_req, src0_vld, src1_vld, src2_vld,
        output src0_data, src1_data, src2_data, src0_dp, src1_dp, src2_dp,
        input  bcd, dp_sel, upd, busy, cur_src
    );
endinterface

// File: rtl/disp_src_sched.sv
// rtl/disp_src_sched.sv - display source scheduler with double-dabble BCD conversion
// Optional leading-zero blanking: define DISP_LZB_EN.
module disp_src_sched #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int PAGE_MS = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    disp_src_sched_if.slave   bus
);
    localparam int PAGE_CYC = CLK_HZ / 1000 * PAGE_MS;
    localparam int CW = (PAGE_CYC > 1) ? $clog2(PAGE_CYC) : 1;
    localparam logic [CW-1:0] PAGE_LAST = CW'(PAGE_CYC - 1);

    typedef enum logic [1:0] {IDLE, LATCH, CONV, LOAD} state_t;

    state_t        state;
    logic          pending;
    logic [CW-1:0] page_cnt;
    logic [4:0]    step;
    logic [19:0]   bin;
    logic [23:0]   acc;
    logic [2:0]    dp_lat;

    logic [1:0]  next_src;
    logic        page_wrap;
    logic        cur_vld;
    logic [19:0] src_data;
    logic [2:0]  src_dp;
    logic [23:0] adj;
    logic [23:0] acc_nx;
    logic [19:0] bin_nx;
    logic [23:0] disp;
    logic [5:0]  dp_nx;

    always_comb begin
        src_data = bus.src0_data;
        src_dp   = bus.src0_dp;
        cur_vld  = bus.src0_vld;
        case (bus.cur_src)
            2'd1: begin src_data = bus.src1_data; src_dp = bus.src1_dp; cur_vld = bus.src1_vld; end
            2'd2: begin src_data = bus.src2_data; src_dp = bus.src2_dp; cur_vld = bus.src2_vld; end
            default: ;
        endcase
    end

    // Alarm preempts; otherwise rotate among requesting {0,1} at page end.
    always_comb begin
        next_src  = bus.cur_src;
        page_wrap = 1'b0;
        if (bus.src2_req)
            next_src = 2'd2;
        else if (bus.cur_src == 2'd2)
            next_src = (bus.src1_req && !bus.src0_req) ? 2'd1 : 2'd0;
        else if (page_cnt == PAGE_LAST) begin
            page_wrap = 1'b1;
            if (bus.cur_src == 2'd0)
                next_src = bus.src1_req ? 2'd1 : 2'd0;
            else
                next_src = bus.src0_req ? 2'd0 : 2'd1;
        end
    end

    always_comb begin
        adj = acc;
        for (int i = 0; i < 6; i++)
            if (acc[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        acc_nx = {adj[22:0], bin[19]};
        bin_nx = {bin[18:0], 1'b0};
    end

    always_comb begin
        disp  = acc;
        dp_nx = (dp_lat <= 3'd5) ? (6'b000001 << dp_lat) : 6'b000000;
`ifdef DISP_LZB_EN
        begin
            logic lead;
            int   dp_eff;
            lead   = 1'b1;
            dp_eff = (dp_lat <= 3'd5) ? int'(dp_lat) : 0;
            for (int i = 5; i >= 1; i--) begin
                if (lead && acc[i*4 +: 4] == 4'd0 && i > dp_eff)
                    disp[i*4 +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            page_cnt    <= '0;
            step        <= '0;
            bin         <= '0;
            acc         <= '0;
            dp_lat      <= 3'd7;
            bus.bcd     <= 24'hFFFFF0;
            bus.dp_sel  <= '0;
            bus.upd     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.cur_src <= 2'd0;
        end else begin
            bus.upd <= 1'b0;
            // Counter parks at its last value until IDLE can act on the page end.
            if (bus.src2_req || bus.cur_src == 2'd2)
                page_cnt <= '0;
            else if (page_cnt != PAGE_LAST)
                page_cnt <= page_cnt + 1'b1;
            if (state != IDLE && cur_vld)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    bus.cur_src <= next_src;
                    if (page_wrap)
                        page_cnt <= '0;
                    if (pending || cur_vld || next_src != bus.cur_src) begin
                        pending  <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    bin    <= (src_data > 20'd999999) ? 20'd999999 : src_data;
                    acc    <= '0;
                    dp_lat <= src_dp;
                    step   <= '0;
                    state  <= CONV;
                end
                CONV: begin
                    acc  <= acc_nx;
                    bin  <= bin_nx;
                    step <= step + 5'd1;
                    if (step == 5'd19)
                        state <= LOAD;
                end
                default: begin
                    bus.bcd    <= disp;
                    bus.dp_sel <= dp_nx;
                    bus.upd    <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_disp_src_sched.sv
// tb/tb_disp_src_sched.sv - scoreboard bench for disp_src_sched
module tb_disp_src_sched;
    localparam int PAGE_CYC = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  dp_sel;
        logic [1:0]  src;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   upd_cycs[$];

    disp_src_sched_if bus ();

    disp_src_sched #(.CLK_HZ(40_000), .PAGE_MS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [23:0] pick(input logic [23:0] lzb, input logic [23:0] plain);
`ifdef DISP_LZB_EN
        return lzb;
`else
        return plain;
`endif
    endfunction

    task automatic push(input logic [23:0] b, input logic [5:0] d, input logic [1:0] s, input int at);
        exp_t e;
        e.bcd = b; e.dp_sel = d; e.src = s; e.at = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            tick(1);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic pulse0(input logic [19:0] data, input logic [2:0] dp, output int c0);
        bus.src0_data = data;
        bus.src0_dp   = dp;
        bus.src0_vld  = 1'b1;
        c0 = cyc;
        tick(1);
        bus.src0_vld  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.upd) begin
            upd_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_upd", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd", bus.bcd, e.bcd);
                chk("dp_sel", bus.dp_sel, e.dp_sel);
                chk("cur_src", bus.cur_src, e.src);
                if (e.at >= 0) chk("latency", cyc, e.at);
            end
        end
    end

    initial begin
        int c;
        bus.src0_req = 1'b1; bus.src1_req = 1'b0; bus.src2_req = 1'b0;
        bus.src0_vld = 1'b0; bus.src1_vld = 1'b0; bus.src2_vld = 1'b0;
        bus.src0_data = '0;  bus.src1_data = 20'd42; bus.src2_data = 20'd999;
        bus.src0_dp = 3'd7;  bus.src1_dp = 3'd7;     bus.src2_dp = 3'd7;
        tick(3);
        chk("rst_bcd", bus.bcd, 24'hFFFFF0);
        chk("rst_dp_sel", bus.dp_sel, 6'd0);
        chk("rst_upd", bus.upd, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cur_src", bus.cur_src, 2'd0);
        rst_n = 1'b1;
        tick(2);

        pulse0(20'd1234, 3'd7, c);
        push(pick(24'hFF1234, 24'h001234), 6'd0, 2'd0, c + 23);
        tick(4);
        chk("busy_mid", bus.busy, 1'b1);
        wait_drain(60);
        tick(1);
        chk("busy_done", bus.busy, 1'b0);

        pulse0(20'd1048575, 3'd7, c);
        push(24'h999999, 6'd0, 2'd0, c + 23);
        wait_drain(60);

        pulse0(20'd5, 3'd2, c);
        push(pick(24'hFFF005, 24'h000005), 6'b000100, 2'd0, c + 23);
        wait_drain(60);

        pulse0(20'd0, 3'd0, c);
        push(pick(24'hFFFFF0, 24'h000000), 6'b000001, 2'd0, c + 23);
        wait_drain(60);

        pulse0(20'd120, 3'd6, c);
        push(pick(24'hFFF120, 24'h000120), 6'd0, 2'd0, c + 23);
        wait_drain(60);

        // Three strobes mid-conversion coalesce into one follow-up conversion.
        pulse0(20'd111, 3'd7, c);
        push(pick(24'hFFF111, 24'h000111), 6'd0, 2'd0, c + 23);
        push(pick(24'hFFF222, 24'h000222), 6'd0, 2'd0, c + 46);
        tick(4);
        for (int i = 0; i < 3; i++) begin
            int dummy;
            pulse0(20'd222, 3'd7, dummy);
            tick(1);
        end
        wait_drain(100);
        tick(40);

        pulse0(20'd777, 3'd7, c);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("arst_bcd", bus.bcd, 24'hFFFFF0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_upd", bus.upd, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("arst_no_upd", sb.size(), 0);

        upd_cycs.delete();
        bus.src1_req = 1'b1;
        push(pick(24'hFFFF42, 24'h000042), 6'd0, 2'd1, -1);
        push(pick(24'hFFF777, 24'h000777), 6'd0, 2'd0, -1);
        push(pick(24'hFFFF42, 24'h000042), 6'd0, 2'd1, -1);
        wait_drain(400);
        chk("page_upd_count", upd_cycs.size(), 3);
        if (upd_cycs.size() == 3) begin
            chk("page_period_a", upd_cycs[1] - upd_cycs[0], PAGE_CYC);
            chk("page_period_b", upd_cycs[2] - upd_cycs[1], PAGE_CYC);
        end

        tick(10);
        bus.src2_req = 1'b1;
        c = cyc;
        push(pick(24'hFFF999, 24'h000999), 6'd0, 2'd2, c + 23);
        wait_drain(60);
        tick(200);
        chk("alarm_hold", bus.cur_src, 2'd2);
        bus.src1_req = 1'b0;
        tick(1);
        bus.src2_req = 1'b0;
        c = cyc;
        push(pick(24'hFFF777, 24'h000777), 6'd0, 2'd0, c + 23);
        wait_drain(60);
        tick(200);
        chk("final_cur_src", bus.cur_src, 2'd0);
        chk("final_queue", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
